// File: rtl/mul_man_arb_if.sv
// Request, multiplier and response bundle for the shared
// mantissa-multiplier arbiter.
interface mul_man_arb_if #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [12*N_REQ-1:0] req_op1;
  logic [12*N_REQ-1:0] req_op2;
  logic [11:0]         mul_op1;
  logic [11:0]         mul_op2;
  logic [15:0]         mul_result;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IDW-1:0]      rsp_id;
  logic [15:0]         rsp_data;

  modport master (
    output req_valid, req_op1, req_op2,
    output mul_result, rsp_ready,
    input  req_ready, mul_op1, mul_op2,
    input  rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_op1, req_op2,
    input  mul_result, rsp_ready,
    output req_ready, mul_op1, mul_op2,
    output rsp_valid, rsp_id, rsp_data
  );
endinterface

// File: rtl/mul_man_arb.sv
// Round-robin scheduler sharing one pipelined mantissa
// multiplier; results are queued in a credit-guarded FIFO.
module mul_man_arb #(
  parameter int N_REQ      = 4,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IDW        = $clog2(N_REQ)
) (
  input logic          clk,
  input logic          rst_n,
  mul_man_arb_if.slave bus_if
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int EW = IDW + 16;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);
  localparam logic [IDW:0] NREQ_C = (IDW+1)'(N_REQ);

  logic [IDW-1:0] rr_ptr_q, rr_ptr_d, win;
  logic [IDW:0]   cand;
  logic           found, issue, push, pop;
  logic [CW-1:0]  credit_cnt_q, credit_cnt_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [LAT-1:0] tv_q;
  logic [IDW-1:0] tid_q [LAT];
  logic [EW-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wp_q, rp_q;
  logic [EW-1:0]  head;

  // Winner: first valid requester scanning from rr_ptr
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDW+1)'(k);
      if (cand >= NREQ_C) cand = cand - NREQ_C;
      if (!found && bus_if.req_valid[cand[IDW-1:0]]) begin
        found = 1'b1;
        win   = cand[IDW-1:0];
      end
    end
  end

  // Credits are registered only; a same-cycle pop
  // does not free a slot until the next cycle.
  assign issue = found & (credit_cnt_q < DEPTH_C) & rst_n;
  assign push  = tv_q[LAT-1];
  assign pop   = bus_if.rsp_valid & bus_if.rsp_ready;

  // One-hot grant and gated operand mux
  always_comb begin
    bus_if.req_ready = '0;
    bus_if.mul_op1   = '0;
    bus_if.mul_op2   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (issue && win == IDW'(i)) begin
        bus_if.req_ready[i] = 1'b1;
        bus_if.mul_op1 = bus_if.req_op1[12*i +: 12];
        bus_if.mul_op2 = bus_if.req_op2[12*i +: 12];
      end
    end
  end

  // Next pointer, credit and occupancy
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (issue) begin
      rr_ptr_d = (win == LAST_ID) ? '0 : win + 1'b1;
    end
    credit_cnt_d = credit_cnt_q;
    if (issue && !pop) credit_cnt_d = credit_cnt_q + 1'b1;
    else if (!issue && pop) credit_cnt_d = credit_cnt_q - 1'b1;
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + 1'b1;
    else if (!push && pop) cnt_d = cnt_q - 1'b1;
  end

  // Control state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q     <= '0;
      credit_cnt_q <= '0;
      cnt_q        <= '0;
      wp_q         <= '0;
      rp_q         <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      credit_cnt_q <= credit_cnt_d;
      cnt_q        <= cnt_d;
      if (push) wp_q <= wp_q + 1'b1;
      if (pop)  rp_q <= rp_q + 1'b1;
    end
  end

  // ID tags travel alongside the multiplier pipeline
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tv_q <= '0;
      for (int k = 0; k < LAT; k++) tid_q[k] <= '0;
    end else begin
      tv_q[0]  <= issue;
      tid_q[0] <= win;
      for (int k = 1; k < LAT; k++) begin
        tv_q[k]  <= tv_q[k-1];
        tid_q[k] <= tid_q[k-1];
      end
    end
  end

  // Result storage; a full-FIFO push cannot occur
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < FIFO_DEPTH; k++) mem_q[k] <= '0;
    end else if (push) begin
      mem_q[wp_q] <= {tid_q[LAT-1], bus_if.mul_result};
    end
  end

  assign head             = mem_q[rp_q];
  assign bus_if.rsp_valid = (cnt_q != '0);
  assign bus_if.rsp_id    =
    bus_if.rsp_valid ? head[EW-1:16] : '0;
  assign bus_if.rsp_data  =
    bus_if.rsp_valid ? head[15:0] : '0;

  a_fifo_ovf: assert property (@(posedge clk)
    disable iff (!rst_n) !(push && !pop && cnt_q == DEPTH_C));
  a_credit_unf: assert property (@(posedge clk)
    disable iff (!rst_n) !(pop && credit_cnt_q == '0));
  a_credit_max: assert property (@(posedge clk)
    disable iff (!rst_n) credit_cnt_q <= DEPTH_C);
endmodule

// File: tb/tb_mul_man_arb.sv
// Directed bench for mul_man_arb with a 2-stage
// multiplier model and an in-order response scoreboard.
module tb_mul_man_arb;
  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  logic [17:0] sbq [$];
  logic [15:0] exp_d [4];
  logic [15:0] p1_q, p2_q;
  logic [23:0] prod;

  mul_man_arb_if #(.N_REQ(4)) bus ();

  mul_man_arb #(
    .N_REQ(4), .LAT(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign prod = bus.mul_op1 * bus.mul_op2;
  assign bus.mul_result = p2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_q <= '0;
      p2_q <= '0;
    end else begin
      p1_q <= prod[23:8];
      p2_q <= p1_q;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic logic [1:0] oh2id(logic [3:0] oh);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (oh[i]) r = 2'(i);
    return r;
  endfunction

  task automatic set_ops(input int i,
                         input logic [11:0] a,
                         input logic [11:0] b,
                         input logic [15:0] d);
    bus.req_op1[12*i +: 12] = a;
    bus.req_op2[12*i +: 12] = b;
    exp_d[i] = d;
  endtask

  task automatic fair_ops();
    set_ops(0, 12'h800, 12'h800, 16'h4000);
    set_ops(1, 12'h800, 12'h400, 16'h2000);
    set_ops(2, 12'h800, 12'h200, 16'h1000);
    set_ops(3, 12'h800, 12'h100, 16'h0800);
  endtask

  task automatic step(input logic [3:0] v,
                      input logic r,
                      input logic [3:0] er,
                      input string tag);
    logic [17:0] e;
    @(negedge clk);
    bus.req_valid = v;
    bus.rsp_ready = r;
    #1;
    chk({tag, "_rdy"}, 32'(bus.req_ready), 32'(er));
    if (er != 4'h0)
      sbq.push_back({oh2id(er), exp_d[oh2id(er)]});
    if (bus.rsp_valid && r) begin
      if (sbq.size() == 0) begin
        chk({tag, "_stray"}, 32'(bus.rsp_valid), 0);
      end else begin
        e = sbq.pop_front();
        chk({tag, "_id"}, 32'(bus.rsp_id), 32'(e[17:16]));
        chk({tag, "_data"}, 32'(bus.rsp_data), 32'(e[15:0]));
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 16; i++) begin
      if (sbq.size() == 0) break;
      step(4'h0, 1'b1, 4'h0, "drain");
    end
    chk("drain_left", sbq.size(), 0);
    step(4'h0, 1'b1, 4'h0, "idle");
    chk("idle_vld", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] p4v [20];
    logic       p4r [20];
    logic [3:0] p4e [20];
    p4v = '{4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf,
            4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf, 4'hf,
            4'hf, 4'hf, 4'he, 4'hc, 4'h8, 4'h0};
    p4r = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0,
            1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
    p4e = '{4'h2, 4'h4, 4'h8, 4'h1, 4'h0, 4'h0, 4'h0,
            4'h0, 4'h0, 4'h2, 4'h0, 4'h4, 4'h8, 4'h0,
            4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h0};
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.req_valid = 4'hf;
    bus.rsp_ready = 1'b0;
    bus.req_op1 = '0;
    bus.req_op2 = '0;
    fair_ops();
    #3;
    chk("rst_rdy", 32'(bus.req_ready), 0);
    chk("rst_vld", 32'(bus.rsp_valid), 0);
    chk("rst_id", 32'(bus.rsp_id), 0);
    chk("rst_data", 32'(bus.rsp_data), 0);
    chk("rst_op1", 32'(bus.mul_op1), 0);
    chk("rst_op2", 32'(bus.mul_op2), 0);
    bus.req_valid = 4'h0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // fairness: grants 0,1,2,3,... rsp ids lag by 3
    for (int k = 0; k < 15; k++) begin
      step((k < 12) ? 4'hf : 4'h0, 1'b1,
           (k < 12) ? 4'(1 << (k % 4)) : 4'h0, "fair");
      chk("fair_vld", 32'(bus.rsp_valid), 32'(k >= 3));
    end
    drain();

    // single op on requester 0
    step(4'h1, 1'b1, 4'h1, "single");
    chk("single_op1", 32'(bus.mul_op1), 32'h800);
    chk("single_op2", 32'(bus.mul_op2), 32'h800);
    step(4'h0, 1'b1, 4'h0, "single");
    chk("single_op1_gate", 32'(bus.mul_op1), 0);
    chk("single_lat1", 32'(bus.rsp_valid), 0);
    step(4'h0, 1'b1, 4'h0, "single");
    chk("single_lat2", 32'(bus.rsp_valid), 0);
    step(4'h0, 1'b1, 4'h0, "single");
    chk("single_lat3", 32'(bus.rsp_valid), 1);
    drain();

    // max operands; req 2 wins over 0 since rr_ptr=1
    set_ops(2, 12'hfff, 12'hfff, 16'hffe0);
    set_ops(0, 12'h100, 12'h100, 16'h0100);
    step(4'h5, 1'b1, 4'h4, "max");
    chk("max_op1", 32'(bus.mul_op1), 32'hfff);
    chk("max_op2", 32'(bus.mul_op2), 32'hfff);
    step(4'h1, 1'b1, 4'h1, "max");
    chk("max_op1_r0", 32'(bus.mul_op1), 32'h100);
    step(4'h0, 1'b1, 4'h0, "max");
    chk("max_op1_gate", 32'(bus.mul_op1), 0);
    chk("max_op2_gate", 32'(bus.mul_op2), 0);
    drain();

    // backpressure, single pop, coincident issue+pop
    fair_ops();
    for (int k = 0; k < 20; k++) begin
      step(p4v[k], p4r[k], p4e[k], "bp");
      if (k >= 4 && k <= 8) begin
        chk("bp_hold_vld", 32'(bus.rsp_valid), 1);
        chk("bp_hold_id", 32'(bus.rsp_id), 1);
        chk("bp_hold_data", 32'(bus.rsp_data), 32'h2000);
      end
    end
    drain();

    // reset with 2 buffered and 2 in flight
    step(4'h6, 1'b0, 4'h2, "mid");
    step(4'h6, 1'b0, 4'h4, "mid");
    step(4'h6, 1'b0, 4'h2, "mid");
    step(4'h6, 1'b0, 4'h4, "mid");
    step(4'h6, 1'b0, 4'h0, "mid");
    chk("mid_vld", 32'(bus.rsp_valid), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.rsp_valid), 0);
    chk("mid_rst_id", 32'(bus.rsp_id), 0);
    chk("mid_rst_data", 32'(bus.rsp_data), 0);
    chk("mid_rst_rdy", 32'(bus.req_ready), 0);
    chk("mid_rst_op1", 32'(bus.mul_op1), 0);
    chk("mid_rst_op2", 32'(bus.mul_op2), 0);
    sbq.delete();
    bus.req_valid = 4'h0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(4'h0, 1'b1, 4'h0, "post");
      chk("post_vld", 32'(bus.rsp_valid), 0);
    end
    step(4'h9, 1'b1, 4'h1, "post");
    step(4'h8, 1'b1, 4'h8, "post");
    chk("post_lat1", 32'(bus.rsp_valid), 0);
    step(4'h0, 1'b1, 4'h0, "post");
    chk("post_lat2", 32'(bus.rsp_valid), 0);
    step(4'h0, 1'b1, 4'h0, "post");
    chk("post_lat3", 32'(bus.rsp_valid), 1);
    step(4'h0, 1'b1, 4'h0, "post");
    chk("post_lat4", 32'(bus.rsp_valid), 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
